// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants for the shift-and-add multiplier: default widths, the
// fixed-point format it shares with the restoring divider, and FSM encodings.
package shift_add_multiplier_pkg;

   localparam int W_DEF    = 10;
   localparam int FRAC_DEF = 0;
   localparam int CW_DEF   = 4;

   localparam int CNT_RELOAD_DEF = W_DEF - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // One iteration per multiplier bit, counting down to zero inclusive.
   function automatic int cnt_reload(input int w);
      return w - 1;
   endfunction

endpackage

// File: rtl/shift_add_multiplier_dp.sv
// Datapath of the shift-and-add multiplier: operand register, {acc, mq}
// shift register with conditional add, iteration counter and zero detect.
module shift_add_dp
   import shift_add_multiplier_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic           clk,
   input  logic           sclr,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   output logic           operand_zero,
   output logic           cnt_zero,
   output logic [2*W-1:0] prod_next
);

   logic [W-1:0]  a_reg;
   logic [W-1:0]  mq;
   logic [W:0]    acc;
   logic [W:0]    sum;
   logic [W:0]    acc_next;
   logic [W-1:0]  mq_next;
   logic [CW-1:0] cnt;

   // Add-then-shift as one step; the carry lands in acc[W] and drops back in.
   always_comb begin
      sum = acc;
      if (mq[0]) begin
         sum = {1'b0, acc[W-1:0]} + {1'b0, a_reg};
      end
      acc_next     = {1'b0, sum[W:1]};
      mq_next      = {sum[0], mq[W-1:1]};
      prod_next    = {acc_next[W-1:0], mq_next};
      operand_zero = (a_in == '0) || (b_in == '0);
      cnt_zero     = (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!sclr) begin
         a_reg <= '0;
         mq    <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (load) begin
         a_reg <= a_in;
         mq    <= b_in;
         acc   <= '0;
         cnt   <= CW'(cnt_reload(W));
      end else if (step) begin
         acc <= acc_next;
         mq  <= mq_next;
         if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add unsigned multiplier with start/done
// handshake, full product, fixed-point result and overflow flag.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic           clk,
   input  logic           sclr,
   input  logic           start,
   input  logic [W-1:0]   A_in,
   input  logic [W-1:0]   B_in,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] P_full,
   output logic [W-1:0]   P_out,
   output logic           ovf
);

   logic [1:0]     state;
   logic           load;
   logic           step;
   logic           operand_zero;
   logic           cnt_zero;
   logic [2*W-1:0] prod_next;
   logic [2*W-1:0] prod_high;

   assign load      = start && ((state == IDLE) || (state == DONE));
   assign step      = (state == CALC);
   assign busy      = (state == CALC);
   assign done      = (state == DONE);
   assign prod_high = prod_next >> (FRAC + W);

   shift_add_dp #(
      .W  (W),
      .CW (CW)
   ) u_dp (
      .clk          (clk),
      .sclr         (sclr),
      .load         (load),
      .step         (step),
      .a_in         (A_in),
      .b_in         (B_in),
      .operand_zero (operand_zero),
      .cnt_zero     (cnt_zero),
      .prod_next    (prod_next)
   );

   // Results are written only on the edge entering DONE and held otherwise.
   always_ff @(posedge clk) begin
      if (!sclr) begin
         state  <= IDLE;
         P_full <= '0;
         P_out  <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (operand_zero) begin
                     state  <= DONE;
                     P_full <= '0;
                     P_out  <= '0;
                     ovf    <= 1'b0;
                  end else begin
                     state <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               if (cnt_zero) begin
                  state  <= DONE;
                  P_full <= prod_next;
                  P_out  <= prod_next[FRAC +: W];
                  ovf    <= |prod_high;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
